// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for the RV32i MEM stage: word array with byte-enabled
// stores, word loads, a fixed number of wait states and an error response for
// misaligned, out-of-window or ambiguous (load+store) requests.
module rv32i_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_re_i,
    input  logic        req_we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    output logic        valid_o,
    output logic        err_o,
    output logic        busy_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       cnt;
    logic [3:0]       cnt_next;
    logic             busy;
    logic             accept;
    logic             resp_err;

    logic [31:0]      mem [DEPTH_WORDS];

    // Request as captured at acceptance; held through the wait states.
    logic [IDX_W-1:0] cap_idx;
    logic [31:0]      cap_wdata;
    logic [3:0]       cap_be;
    logic             cap_we;
    logic             cap_err;

    // Live decode of the request lines.
    logic             req;
    logic [31:0]      offset;
    logic [IDX_W-1:0] req_idx;
    logic             req_err;

    // Access being committed on the coming edge.
    logic             commit;
    logic [IDX_W-1:0] com_idx;
    logic [31:0]      com_wdata;
    logic [3:0]       com_be;
    logic             com_we;
    logic             com_err;

    assign req     = req_re_i | req_we_i;
    assign offset  = addr_i - BASE_ADDR;
    assign req_idx = offset[IDX_W+1:2];
    // Addresses outside the window are errors; there is no wrap-around.
    assign req_err = (addr_i[1:0] != 2'b00)
                   || (addr_i < BASE_ADDR)
                   || ((offset >> 2) >= 32'(DEPTH_WORDS))
                   || (req_re_i && req_we_i);

    // With zero wait states the access commits on its acceptance edge, so the
    // live request is used directly; otherwise the captured copy is used.
    always_comb begin
        commit    = 1'b0;
        com_idx   = cap_idx;
        com_wdata = cap_wdata;
        com_be    = cap_be;
        com_we    = cap_we;
        com_err   = cap_err;
        if (state == IDLE) begin
            commit    = req && (WAIT_CYCLES == 0) && !rst_i;
            com_idx   = req_idx;
            com_wdata = wdata_i;
            com_be    = be_i;
            com_we    = req_we_i;
            com_err   = req_err;
        end else if (state == WAIT) begin
            commit = (cnt == 4'd0) && !rst_i;
        end
    end

    // Next-state logic and the pipeline-freeze request.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    busy   = 1'b1;
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_o  = busy && !rst_i;
    assign valid_o = (state == RESP);
    assign err_o   = (state == RESP) && resp_err;

    // Control state, response flag and load data register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            resp_err <= 1'b0;
            rdata_o  <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (commit) begin
                resp_err <= com_err;
                if (com_err) begin
                    rdata_o <= 32'd0;
                end else if (!com_we) begin
                    rdata_o <= mem[com_idx];
                end
            end
        end
    end

    // Capture the request on acceptance; data path needs no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            cap_idx   <= req_idx;
            cap_wdata <= wdata_i;
            cap_be    <= be_i;
            cap_we    <= req_we_i;
            cap_err   <= req_err;
        end
    end

    // Byte-lane store into the array at the commit edge.
    always_ff @(posedge clk_i) begin
        if (commit && com_we && !com_err) begin
            for (int n = 0; n < 4; n++) begin
                if (com_be[n]) begin
                    mem[com_idx][8*n +: 8] <= com_wdata[8*n +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench for rv32i_dmem_responder: one instance with two wait states,
// one with none; expected responses queued at drive time, compared on valid_o.
module tb_rv32i_dmem_responder;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_re, a_we, a_valid, a_err, a_busy;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        b_rst, b_re, b_we, b_valid, b_err, b_busy;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;

    rv32i_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(32'h2000)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .req_re_i(a_re), .req_we_i(a_we), .addr_i(a_addr),
        .wdata_i(a_wdata), .be_i(a_be), .rdata_o(a_rdata), .valid_o(a_valid),
        .err_o(a_err), .busy_o(a_busy)
    );

    rv32i_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h2000)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .req_re_i(b_re), .req_we_i(b_we), .addr_i(b_addr),
        .wdata_i(b_wdata), .be_i(b_be), .rdata_o(b_rdata), .valid_o(b_valid),
        .err_o(b_err), .busy_o(b_busy)
    );

    // Selected instance's outputs.
    logic        sel = 1'b0;
    logic        o_valid, o_err, o_busy;
    logic [31:0] o_rdata;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_err   = sel ? b_err   : a_err;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_rdata = sel ? b_rdata : a_rdata;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];
    int    total  = 0;
    int    passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic e_err, input logic e_chk, input logic [31:0] e_data);
        exp_t e;
        e.err  = e_err;
        e.chk  = e_chk;
        e.data = e_data;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic pop_check();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard: got unexpected response expected none");
        end else begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            check({t, ".err"}, {31'd0, o_err}, {31'd0, e.err});
            if (e.chk) check({t, ".rdata"}, o_rdata, e.data);
        end
    endtask

    task automatic set_req(input logic s, input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        if (s) begin
            b_re = re; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
        end else begin
            a_re = re; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
        end
    endtask

    // Hold a request until valid_o, checking busy_o each cycle and the latency.
    task automatic access(input logic s, input logic re, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic e_err,
                          input logic e_chk, input logic [31:0] e_data, input int lat,
                          input string tag);
        int   n;
        logic got;
        sel = s;
        push(tag, e_err, e_chk, e_data);
        @(posedge clk); #1;
        set_req(s, re, we, addr, wdata, be);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (o_valid) begin
                got = 1'b1;
                check({tag, ".lat"}, 32'(n), 32'(lat));
                check({tag, ".busy_resp"}, {31'd0, o_busy}, 32'd0);
                pop_check();
            end else begin
                if (o_busy !== 1'b1) check({tag, ".busy_wait"}, {31'd0, o_busy}, 32'd1);
                n++;
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            total++;
            $error("FAIL %s.timeout: got no valid_o expected valid_o", tag);
            void'(sb.pop_front());
            void'(sb_tag.pop_front());
        end
        @(posedge clk); #1;
        set_req(s, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.valid", {31'd0, a_valid}, 32'd0);
        check("rst.err",   {31'd0, a_err},   32'd0);
        check("rst.busy",  {31'd0, a_busy},  32'd0);
        check("rst.rdata", a_rdata,          32'd0);
        a_rst = 1'b0; b_rst = 1'b0;

        // Two wait states: latency 3 cycles.
        access(0, 0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 32'd0, 3, "st2000");
        access(0, 1, 0, 32'h2000, 32'd0, 4'h0, 0, 1, 32'hDEADBEEF, 3, "ld2000");
        // Write response leaves rdata_o untouched.
        access(0, 0, 1, 32'h2008, 32'h55667788, 4'hF, 0, 1, 32'hDEADBEEF, 3, "st2008_hold");
        access(0, 0, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 0, 0, 32'd0, 3, "st2004");
        access(0, 0, 1, 32'h2004, 32'h11223344, 4'b0101, 0, 0, 32'd0, 3, "st2004_be");
        access(0, 1, 0, 32'h2004, 32'd0, 4'h0, 0, 1, 32'hDE22BE44, 3, "ld2004_be");
        access(0, 0, 1, 32'h2000, 32'h01234567, 4'h0, 0, 0, 32'd0, 3, "st2000_be0");
        access(0, 1, 0, 32'h2000, 32'd0, 4'h0, 0, 1, 32'hDEADBEEF, 3, "ld2000_be0");
        access(0, 1, 0, 32'h2008, 32'd0, 4'h0, 0, 1, 32'h55667788, 3, "ld2008");

        // Error responses.
        access(0, 1, 0, 32'h2002, 32'd0, 4'h0, 1, 1, 32'd0, 3, "ld_misalign");
        access(0, 1, 0, 32'h2000 + 4*DEPTH, 32'd0, 4'h0, 1, 1, 32'd0, 3, "ld_past_end");
        access(0, 1, 0, 32'h2000 + 4*DEPTH - 4, 32'd0, 4'h0, 0, 0, 32'd0, 3, "ld_last_word");
        access(0, 0, 1, 32'h1FFC, 32'h0BADF00D, 4'hF, 1, 0, 32'd0, 3, "st_below");
        access(0, 1, 0, 32'h2000, 32'd0, 4'h0, 0, 1, 32'hDEADBEEF, 3, "ld2000_after_below");
        access(0, 1, 1, 32'h2000, 32'h0, 4'hF, 1, 1, 32'd0, 3, "rw_both");
        access(0, 1, 0, 32'h2000, 32'd0, 4'h0, 0, 1, 32'hDEADBEEF, 3, "ld2000_after_both");

        // Reset during WAIT of a store discards it.
        access(0, 0, 1, 32'h2010, 32'h0, 4'hF, 0, 1, 32'hDEADBEEF, 3, "st2010_zero");
        sel = 1'b0;
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b1, 32'h2010, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        check("midrst.busy0", {31'd0, a_busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("midrst.busy1", {31'd0, a_busy}, 32'd1);
        #1;
        a_rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        check("midrst.valid", {31'd0, a_valid}, 32'd0);
        check("midrst.err",   {31'd0, a_err},   32'd0);
        check("midrst.busy",  {31'd0, a_busy},  32'd0);
        check("midrst.rdata", a_rdata,          32'd0);
        @(posedge clk); #1;
        a_rst = 1'b0;
        @(negedge clk);
        check("midrst.idle_valid", {31'd0, a_valid}, 32'd0);
        access(0, 1, 0, 32'h2010, 32'd0, 4'h0, 0, 1, 32'h0, 3, "ld2010_after_rst");

        // Zero wait states: preload, then back-to-back loads.
        for (int i = 0; i < 4; i++)
            access(1, 0, 1, 32'h2000 + 32'(4*i), 32'hA5000000 + 32'(i*17), 4'hF, 0, 0, 32'd0, 1, "b_st");
        sel = 1'b1;
        for (int i = 0; i < 4; i++) push("b_b2b", 1'b0, 1'b1, 32'hA5000000 + 32'(i*17));
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            set_req(1, 1'b1, 1'b0, 32'h2000 + 32'(4*(k/2)), 32'd0, 4'd0);
            @(negedge clk);
            if (k % 2 == 0) begin
                check("b2b.busy_req", {31'd0, b_busy},  32'd1);
                check("b2b.no_valid", {31'd0, b_valid}, 32'd0);
            end else begin
                check("b2b.valid",     {31'd0, b_valid}, 32'd1);
                check("b2b.busy_resp", {31'd0, b_busy},  32'd0);
                if (b_valid) pop_check();
            end
        end
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("sb.empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rv32i_dmem_responder.md
Name: rv32i_dmem_responder

Overview:
- Data-memory responder for the RV32i pipeline. It sits on the far side of the core's MEM-stage load/store request lines.
- Serves word-aligned reads and byte-enabled writes from an internal word array, with a parameterised number of wait states.
- Drives busy_o to freeze the pipeline, and valid_o/err_o to complete each access.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >=4).
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response (0..15).
- BASE_ADDR, 32'h0000_2000, byte address of word 0 (DEPTH_WORDS*4 aligned).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- req_re_i  in  1  load request from MEM stage.
- req_we_i  in  1  store request from MEM stage.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, lane-aligned.
- be_i  in  4  byte enables for stores, bit n = byte n (wdata_i[8n+7:8n]).
- rdata_o  out  32  load data, valid while valid_o=1.
- valid_o  out  1  one-cycle access completion pulse.
- err_o  out  1  error flag, qualified by valid_o.
- busy_o  out  1  core must hold the pipeline and the request stable.

Behaviour:
- Reset: state=IDLE, wait counter=0, rdata_o=0, valid_o=0, err_o=0, busy_o=0. The array has no reset; its contents are preserved.
- Reset mid-access discards the captured request. A write not yet committed is not performed.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - A request exists when req_re_i|req_we_i.
  - busy_o = request exists (combinational, same cycle).
  - At the clock edge, capture addr_i, wdata_i, be_i and the type.
  - Go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else go directly to RESP.
- WAIT:
  - busy_o=1; inputs are ignored.
  - Counter decrements each cycle; at counter==0 go to RESP.
- RESP:
  - valid_o=1, busy_o=0, for exactly one cycle, then IDLE.
  - A request still present during RESP is the completed one and is not re-accepted. The next acceptance is the first IDLE cycle.
- Latency: request first visible in cycle 0 gives valid_o in cycle WAIT_CYCLES+1. Back-to-back accesses therefore have a period of WAIT_CYCLES+2.
- Commit point: on the edge entering RESP.
  - Write: update bytes with be_i[n]=1; other bytes are unchanged. be_i=0 is a legal no-op write.
  - Read: register the word into rdata_o.
  - A read following a write to the same word returns the new data.
- rdata_o hold rules:
  - Unchanged after a write response.
  - Holds its value until the next read response or error.
- Errors: err_o=1 with valid_o in RESP, no array update, rdata_o=0, when any of the following holds:
  - addr_i[1:0]!=0;
  - addr_i<BASE_ADDR;
  - (addr_i-BASE_ADDR)>>2 >= DEPTH_WORDS;
  - req_re_i and req_we_i are both 1.
- Error timing is identical to the normal latency.
- Word index = (addr_i-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. There is no address wrap-around; out-of-range addresses are errors.
- err_o=0 and valid_o=0 outside RESP.

Test Plan:
- Reset, WAIT_CYCLES=2:
  - Store 32'hDEADBEEF, be_i=4'hF, to 32'h2000 with req held until valid_o.
  - Required: busy_o=1 in cycles 0-2; valid_o=1, err_o=0 in cycle 3.
  - Then a load of 32'h2000 returns rdata_o=32'hDEADBEEF in its RESP cycle.
- Byte enables:
  - Store 32'h11223344, be_i=4'b0101, over a word holding 32'hDEADBEEF at 32'h2004.
  - Required: a subsequent load returns 32'hDE22BE44.
- Errors:
  - Load at 32'h2002 -> valid_o=1, err_o=1, rdata_o=0.
  - Load at 32'h2000+4*DEPTH_WORDS -> err_o=1.
  - Store at 32'h1FFC -> err_o=1, and a reload of 32'h2000 is unchanged.
- WAIT_CYCLES=0:
  - Four back-to-back loads at 32'h2000/4/8/C.
  - Required: valid_o every second cycle, busy_o high in each request's first cycle only, data in order.
- Reset mid-access:
  - Assert rst_i during WAIT of a store of 32'hCAFEF00D to 32'h2010 (old value 32'h0).
  - Required: outputs go to 0 immediately, state returns to IDLE, and a later load of 32'h2010 returns 32'h0.
- Simultaneous req_re_i=req_we_i=1 at 32'h2000:
  - Required: err_o=1 and the memory word is unchanged.
